// File: rtl/adder_pipe.sv
// adder_pipe: WIDTH-bit add/subtract unit split into STAGES equal chunks.
// Each pipeline stage resolves one CW-bit chunk, so the carry chain per
// cycle is CW = WIDTH/STAGES bits. Operands and results use valid/ready
// with full back-pressure: the whole pipe advances together or holds.
// Optional feature: define ADDER_PIPE_OVERFLOW_EN to add the overflow_o
// port (signed overflow, aligned with sum_o).
module adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  input  logic             sub_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
`ifdef ADDER_PIPE_OVERFLOW_EN
  ,
  output logic             overflow_o
`endif
);

  localparam int CW = WIDTH / STAGES;

  // Effective operands: subtraction is A + ~B + ~borrow.
  logic [WIDTH-1:0] b_eff_s;
  logic             c_eff_s;
  logic             adv_s;

  assign b_eff_s = sub_i ? ~b_i : b_i;
  assign c_eff_s = carry_i ^ sub_i;

  // Global advance: the pipe moves unless a finished result is blocked.
  assign adv_s   = !valid_o || ready_i;
  assign ready_o = adv_s;

  // Per-stage state. Operand registers carry the still-unresolved upper
  // chunks; sum_r holds the chunks resolved so far.
  logic             v_r   [STAGES];
  logic [WIDTH-1:0] a_r   [STAGES];
  logic [WIDTH-1:0] b_r   [STAGES];
  logic [WIDTH-1:0] sum_r [STAGES];
  logic             c_r   [STAGES];

  // Per-stage next-state values.
  logic             src_v_s   [STAGES];
  logic [WIDTH-1:0] src_a_s   [STAGES];
  logic [WIDTH-1:0] src_b_s   [STAGES];
  logic [WIDTH-1:0] src_sum_s [STAGES];
  logic             src_c_s   [STAGES];
  logic [WIDTH-1:0] nxt_sum_s [STAGES];
  logic             nxt_c_s   [STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CW:0]      chunk_s;
    logic [WIDTH-1:0] merged_s;

    if (k == 0) begin : g_src_in
      assign src_v_s[k]   = valid_i;
      assign src_a_s[k]   = a_i;
      assign src_b_s[k]   = b_eff_s;
      assign src_c_s[k]   = c_eff_s;
      assign src_sum_s[k] = {WIDTH{1'b0}};
    end else begin : g_src_prev
      assign src_v_s[k]   = v_r[k-1];
      assign src_a_s[k]   = a_r[k-1];
      assign src_b_s[k]   = b_r[k-1];
      assign src_c_s[k]   = c_r[k-1];
      assign src_sum_s[k] = sum_r[k-1];
    end

    // Chunk k add: a CW-bit ripple with carry-in from the previous chunk.
    assign chunk_s = {1'b0, src_a_s[k][k*CW +: CW]}
                   + {1'b0, src_b_s[k][k*CW +: CW]}
                   + {{CW{1'b0}}, src_c_s[k]};

    // Merge the freshly resolved chunk into the partial sum.
    always_comb begin
      merged_s = src_sum_s[k];
      merged_s[k*CW +: CW] = chunk_s[CW-1:0];
    end

    assign nxt_sum_s[k] = merged_s;
    assign nxt_c_s[k]   = chunk_s[CW];
  end

  // Pipeline registers: cleared on reset, all stages shift together on advance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < STAGES; k++) begin
        v_r[k]   <= 1'b0;
        a_r[k]   <= {WIDTH{1'b0}};
        b_r[k]   <= {WIDTH{1'b0}};
        sum_r[k] <= {WIDTH{1'b0}};
        c_r[k]   <= 1'b0;
      end
    end else if (adv_s) begin
      for (int k = 0; k < STAGES; k++) begin
        v_r[k]   <= src_v_s[k];
        a_r[k]   <= src_a_s[k];
        b_r[k]   <= src_b_s[k];
        sum_r[k] <= nxt_sum_s[k];
        c_r[k]   <= nxt_c_s[k];
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        v_r[k]   <= v_r[k];
        a_r[k]   <= a_r[k];
        b_r[k]   <= b_r[k];
        sum_r[k] <= sum_r[k];
        c_r[k]   <= c_r[k];
      end
    end
  end

  assign valid_o = v_r[STAGES-1];
  assign sum_o   = sum_r[STAGES-1];
  assign carry_o = c_r[STAGES-1];

  // The last stage has no further chunk to resolve; its operand copies are
  // dead and left for synthesis to trim.
  logic unused_s;
  assign unused_s = ^{a_r[STAGES-1], b_r[STAGES-1]};

`ifdef ADDER_PIPE_OVERFLOW_EN
  // Signed overflow uses the operand sign bits entering the last stage.
  logic ovf_nxt_s;
  logic ovf_r;

  assign ovf_nxt_s = (src_a_s[STAGES-1][WIDTH-1] == src_b_s[STAGES-1][WIDTH-1])
                  && (nxt_sum_s[STAGES-1][WIDTH-1] != src_a_s[STAGES-1][WIDTH-1]);

  // Overflow flag register, advancing in lockstep with the last stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_r <= 1'b0;
    end else if (adv_s) begin
      ovf_r <= ovf_nxt_s;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign overflow_o = ovf_r;
`endif

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe: directed vector table, hand-written
// stall/reset sequences, random streams against a full-width reference
// model, and small STAGES=1 / WIDTH=16,STAGES=2 instances.
module tb_adder_pipe;

  logic        clk;
  logic        rst_ni;
  logic        valid_i, ready_i, carry_i, sub_i;
  logic [31:0] a_i, b_i;
  logic        ready_o, valid_o, carry_o;
  logic [31:0] sum_o;
`ifdef ADDER_PIPE_OVERFLOW_EN
  logic        overflow_o, s1_ovf, s2_ovf;
`endif

  logic        s1_valid, s1_ready, s1_valid_o, s1_carry;
  logic [31:0] s1_a, s1_b, s1_sum;
  logic        s2_valid, s2_ready, s2_valid_o, s2_carry;
  logic [15:0] s2_a, s2_b, s2_sum;
  logic        sw_ready_i;
  logic        sw_zero;

  int errors = 0;
  int checks = 0;

  adder_pipe #(.WIDTH(32), .STAGES(4)) u_dut (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .a_i(a_i), .b_i(b_i), .carry_i(carry_i), .sub_i(sub_i),
    .valid_o(valid_o), .ready_i(ready_i), .sum_o(sum_o), .carry_o(carry_o)
`ifdef ADDER_PIPE_OVERFLOW_EN
    , .overflow_o(overflow_o)
`endif
  );

  adder_pipe #(.WIDTH(32), .STAGES(1)) u_s1 (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(s1_valid), .ready_o(s1_ready),
    .a_i(s1_a), .b_i(s1_b), .carry_i(sw_zero), .sub_i(sw_zero),
    .valid_o(s1_valid_o), .ready_i(sw_ready_i), .sum_o(s1_sum), .carry_o(s1_carry)
`ifdef ADDER_PIPE_OVERFLOW_EN
    , .overflow_o(s1_ovf)
`endif
  );

  adder_pipe #(.WIDTH(16), .STAGES(2)) u_s2 (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(s2_valid), .ready_o(s2_ready),
    .a_i(s2_a), .b_i(s2_b), .carry_i(sw_zero), .sub_i(sw_zero),
    .valid_o(s2_valid_o), .ready_i(sw_ready_i), .sum_o(s2_sum), .carry_o(s2_carry)
`ifdef ADDER_PIPE_OVERFLOW_EN
    , .overflow_o(s2_ovf)
`endif
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: {ovf, carry, sum} from a plain full-width add.
  function automatic logic [33:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic c, input logic s);
    logic [31:0] beff;
    logic [32:0] full;
    logic        ovf;
    beff = s ? ~b : b;
    full = {1'b0, a} + {1'b0, beff} + {32'd0, c ^ s};
    ovf  = (a[31] == beff[31]) && (full[31] != a[31]);
    return {ovf, full};
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[12];

  task automatic run_stream(input int n, input int st_lo, input int st_len, input string tag,
                            output int first, output int last);
    logic [33:0] q[$];
    logic [33:0] e;
    logic [31:0] oa, ob;
    logic        oc, os;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0; first = -1; last = -1;
    oa = $urandom; ob = $urandom;
    oc = 1'($urandom_range(0, 1)); os = 1'($urandom_range(0, 1));
    while (got < n && cyc < n + 200) begin
      @(negedge clk);
      ready_i = (cyc >= st_lo && cyc < st_lo + st_len) ? 1'b0 : 1'b1;
      valid_i = (sent < n) ? 1'b1 : 1'b0;
      a_i = oa; b_i = ob; carry_i = oc; sub_i = os;
      #1;
      chk({tag, " ready_o"}, 64'(ready_o), 64'(!valid_o || ready_i));
      if (valid_o) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s spurious_valid: got valid_o=1 expected no result pending", tag);
        end else begin
          e = q[0];
          chk({tag, " sum"}, 64'(sum_o), 64'(e[31:0]));
          chk({tag, " carry"}, 64'(carry_o), 64'(e[32]));
`ifdef ADDER_PIPE_OVERFLOW_EN
          chk({tag, " ovf"}, 64'(overflow_o), 64'(e[33]));
`endif
          if (ready_i) begin
            void'(q.pop_front());
            got++;
            if (first < 0) first = cyc;
            last = cyc;
          end
        end
      end
      if (valid_i && ready_o) begin
        q.push_back(ref_add(oa, ob, oc, os));
        sent++;
        oa = $urandom; ob = $urandom;
        oc = 1'($urandom_range(0, 1)); os = 1'($urandom_range(0, 1));
      end
      cyc++;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    chk({tag, " result_count"}, 64'(got), 64'(n));
  endtask

  initial begin
    int lat;
    int pulses;
    int first, last;

    vecs[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[2]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    vecs[3]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0};
    vecs[4]  = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
    vecs[5]  = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1};
    vecs[6]  = '{32'h0000_0007, 32'h0000_0007, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[7]  = '{32'h0000_0010, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_000C, 1'b1, 1'b0};
    vecs[8]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[9]  = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
    vecs[10] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};

    rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b1; carry_i = 1'b0; sub_i = 1'b0;
    a_i = 32'd0; b_i = 32'd0;
    s1_valid = 1'b0; s1_a = 32'd0; s1_b = 32'd0;
    s2_valid = 1'b0; s2_a = 16'd0; s2_b = 16'd0;
    sw_ready_i = 1'b1; sw_zero = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst valid_o", 64'(valid_o), 64'd0);
    chk("rst sum_o", 64'(sum_o), 64'd0);
    chk("rst carry_o", 64'(carry_o), 64'd0);
`ifdef ADDER_PIPE_OVERFLOW_EN
    chk("rst overflow_o", 64'(overflow_o), 64'd0);
`endif
    rst_ni = 1'b1;
    #1;
    chk("rst ready_o", 64'(ready_o), 64'd1);

    // STAGES=1 and WIDTH=16/STAGES=2 instances.
    @(negedge clk);
    s1_a = 32'hFFFF_FFFF; s1_b = 32'h0000_0001; s1_valid = 1'b1;
    s2_a = 16'hFFFF; s2_b = 16'h0001; s2_valid = 1'b1;
    #1;
    chk("s1 ready_o", 64'(s1_ready), 64'd1);
    chk("s2 ready_o", 64'(s2_ready), 64'd1);
    @(negedge clk);
    s1_valid = 1'b0; s2_valid = 1'b0;
    chk("s1 valid_o lat1", 64'(s1_valid_o), 64'd1);
    chk("s1 sum", 64'(s1_sum), 64'd0);
    chk("s1 carry", 64'(s1_carry), 64'd1);
    chk("s2 valid_o early", 64'(s2_valid_o), 64'd0);
    @(negedge clk);
    chk("s1 valid_o after", 64'(s1_valid_o), 64'd0);
    chk("s2 valid_o lat2", 64'(s2_valid_o), 64'd1);
    chk("s2 sum", 64'(s2_sum), 64'd0);
    chk("s2 carry", 64'(s2_carry), 64'd1);

    // Directed vectors, one at a time, with latency measurement.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      a_i = vecs[i].a; b_i = vecs[i].b; carry_i = vecs[i].cin; sub_i = vecs[i].sub;
      valid_i = 1'b1; ready_i = 1'b1;
      #1;
      chk($sformatf("vec%0d ready_o", i), 64'(ready_o), 64'd1);
      @(posedge clk);
      lat = 0;
      while (lat < 20) begin
        @(negedge clk);
        valid_i = 1'b0;
        lat++;
        if (valid_o) break;
      end
      chk($sformatf("vec%0d latency", i), 64'(lat), 64'd4);
      chk($sformatf("vec%0d sum", i), 64'(sum_o), 64'(vecs[i].sum));
      chk($sformatf("vec%0d carry", i), 64'(carry_o), 64'(vecs[i].cout));
`ifdef ADDER_PIPE_OVERFLOW_EN
      chk($sformatf("vec%0d ovf", i), 64'(overflow_o), 64'(vecs[i].ovf));
`endif
    end

    // Empty pipe with ready_i low: accepts, fills, stalls only at the output.
    @(negedge clk);
    ready_i = 1'b0; valid_i = 1'b1;
    a_i = 32'h0000_00FF; b_i = 32'h0000_0001; carry_i = 1'b0; sub_i = 1'b0;
    #1;
    chk("fill ready_o", 64'(ready_o), 64'd1);
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("fill valid_o early", 64'(valid_o), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall valid_o", 64'(valid_o), 64'd1);
      chk("stall sum", 64'(sum_o), 64'h100);
      chk("stall ready_o", 64'(ready_o), 64'd0);
    end
    ready_i = 1'b1;
    @(negedge clk);
    chk("stall drained", 64'(valid_o), 64'd0);

    // Back-pressure mid-stream.
    run_stream(10, 6, 5, "bp", first, last);

    // Full throughput.
    repeat (6) @(negedge clk);
    run_stream(100, 0, 0, "tp", first, last);
    chk("tp first_result_cycle", 64'(first), 64'd4);
    chk("tp back_to_back", 64'(last - first), 64'd99);

    // Reset with three operations in flight.
    repeat (6) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a_i = 32'hA5A5_0000 + 32'(i); b_i = 32'h1111_1111; carry_i = 1'b1; sub_i = 1'b0;
      valid_i = 1'b1; ready_i = 1'b1;
    end
    @(negedge clk);
    valid_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("midrst valid_o", 64'(valid_o), 64'd0);
    chk("midrst sum_o", 64'(sum_o), 64'd0);
    chk("midrst carry_o", 64'(carry_o), 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (valid_o) pulses++;
    end
    chk("midrst stale_results", 64'(pulses), 64'd0);
    chk("midrst ready_o", 64'(ready_o), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
